// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave, fully in the SysClk domain.
// Decodes a CMD / SIZE / PAYLOAD framing and moves payload bytes between the
// SPI master and per-channel tx/rx byte memories.
module spi_cmd_slave #(
  parameter int unsigned AddrBits  = 12,
  parameter int unsigned ChanBits  = 2,
  parameter int unsigned SizeBytes = 4
) (
  input  logic                   SysClk,
  input  logic                   Reset,
  input  logic                   SPI_CLK,
  input  logic                   SPI_MOSI,
  input  logic                   SPI_SS,
  output logic                   SPI_MISO,
  input  logic [7:0]             statusIn,
  output logic [AddrBits-1:0]    txMemAddr,
  output logic [ChanBits-1:0]    txMemChan,
  input  logic [7:0]             txMemData,
  output logic [AddrBits-1:0]    rcMemAddr,
  output logic [ChanBits-1:0]    rcMemChan,
  output logic [7:0]             rcMemData,
  output logic                   rcMemWE,
  output logic                   xferDone,
  output logic                   xferAbort,
  output logic [8*SizeBytes-1:0] xferLen
);

  localparam int unsigned CntW = 8 * SizeBytes;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_SIZE,
    ST_PAYLOAD,
    ST_IGNORE
  } state_t;

  // Synchroniser and edge-detect registers
  logic [1:0] sck_sync_q, sck_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] ss_sync_q, ss_sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic       ss_prev_q, ss_prev_d;

  // Protocol state
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [ChanBits-1:0] chan_q, chan_d;
  logic              get_q, get_d;
  logic [CntW-1:0]   size_q, size_d;
  logic [7:0]        size_cnt_q, size_cnt_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;

  // Registered outputs
  logic [AddrBits-1:0] tx_mem_addr_q, tx_mem_addr_d;
  logic [ChanBits-1:0] tx_mem_chan_q, tx_mem_chan_d;
  logic [AddrBits-1:0] rc_mem_addr_q, rc_mem_addr_d;
  logic [ChanBits-1:0] rc_mem_chan_q, rc_mem_chan_d;
  logic [7:0]          rc_mem_data_q, rc_mem_data_d;
  logic                rc_mem_we_q, rc_mem_we_d;
  logic                xfer_done_q, xfer_done_d;
  logic                xfer_abort_q, xfer_abort_d;
  logic [CntW-1:0]     xfer_len_q, xfer_len_d;

  // Synchronised pins and single-cycle edge events
  logic sck_s, mosi_s, ss_s;
  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic byte_done;
  logic [7:0] rx_byte;
  logic [CntW-1:0] size_new;

  // Synchroniser shift and edge detection
  always_comb begin
    sck_sync_d  = {sck_sync_q[0], SPI_CLK};
    mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};
    ss_sync_d   = {ss_sync_q[0], SPI_SS};
    sck_s       = sck_sync_q[1];
    mosi_s      = mosi_sync_q[1];
    ss_s        = ss_sync_q[1];
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    sck_rise    = sck_s & ~sck_prev_q;
    sck_fall    = ~sck_s & sck_prev_q;
    ss_fall     = ~ss_s & ss_prev_q;
    ss_rise     = ss_s & ~ss_prev_q;
    rx_byte     = {rx_shift_q, mosi_s};
    byte_done   = ~ss_s & sck_rise & (bit_cnt_q == 3'd7);
    size_new    = (size_q << 8) | CntW'(rx_byte);
  end

  // Next-state logic: bit/byte engine and framing state machine
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    chan_d        = chan_q;
    get_d         = get_q;
    size_d        = size_q;
    size_cnt_d    = size_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    tx_mem_addr_d = tx_mem_addr_q;
    tx_mem_chan_d = tx_mem_chan_q;
    rc_mem_addr_d = rc_mem_addr_q;
    rc_mem_chan_d = rc_mem_chan_q;
    rc_mem_data_d = rc_mem_data_q;
    rc_mem_we_d   = 1'b0;
    xfer_done_d   = 1'b0;
    xfer_abort_d  = 1'b0;
    xfer_len_d    = xfer_len_q;

    if (ss_fall) begin
      bit_cnt_d  = '0;
      state_d    = ST_CMD;
      tx_shift_d = '0;
    end else if (ss_rise) begin
      // Partial bits are dropped; any in-flight transfer is reported as aborted.
      bit_cnt_d = '0;
      if (state_q == ST_SIZE || state_q == ST_PAYLOAD) begin
        xfer_abort_d = 1'b1;
        xfer_len_d   = byte_cnt_q;
      end
      state_d = ST_CMD;
    end else if (!ss_s) begin
      if (sck_rise) begin
        rx_shift_d = rx_byte[6:0];
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end else if (sck_fall && bit_cnt_q != 3'd0) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end

      if (byte_done) begin
        unique case (state_q)
          ST_CMD: begin
            chan_d     = rx_byte[ChanBits-1:0];
            size_d     = '0;
            size_cnt_d = '0;
            byte_cnt_d = '0;
            unique case (rx_byte[7:6])
              2'b00: tx_shift_d = statusIn;
              2'b01: begin
                get_d         = 1'b1;
                state_d       = ST_SIZE;
                tx_mem_addr_d = '0;
                tx_mem_chan_d = rx_byte[ChanBits-1:0];
                tx_shift_d    = '0;
              end
              2'b10: begin
                get_d      = 1'b0;
                state_d    = ST_SIZE;
                tx_shift_d = '0;
              end
              default: begin
                state_d    = ST_IGNORE;
                tx_shift_d = '0;
              end
            endcase
          end
          ST_SIZE: begin
            size_d     = size_new;
            size_cnt_d = size_cnt_q + 8'd1;
            if (size_cnt_q == 8'(SizeBytes - 1)) begin
              if (size_new == '0) begin
                xfer_done_d = 1'b1;
                xfer_len_d  = '0;
                state_d     = ST_CMD;
              end else begin
                state_d = ST_PAYLOAD;
                if (get_q) begin
                  // Address 0 has been presented since the command byte.
                  tx_shift_d    = txMemData;
                  tx_mem_addr_d = tx_mem_addr_q + AddrBits'(1);
                end
              end
            end
          end
          ST_PAYLOAD: begin
            if (get_q) begin
              tx_shift_d    = txMemData;
              tx_mem_addr_d = tx_mem_addr_q + AddrBits'(1);
            end else begin
              rc_mem_we_d   = 1'b1;
              rc_mem_data_d = rx_byte;
              rc_mem_addr_d = byte_cnt_q[AddrBits-1:0];
              rc_mem_chan_d = chan_q;
            end
            byte_cnt_d = byte_cnt_q + CntW'(1);
            if (byte_cnt_q == size_q - CntW'(1)) begin
              xfer_done_d = 1'b1;
              xfer_len_d  = size_q;
              state_d     = ST_CMD;
              tx_shift_d  = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '1;
      sck_prev_q    <= 1'b0;
      ss_prev_q     <= 1'b1;
      state_q       <= ST_CMD;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      chan_q        <= '0;
      get_q         <= 1'b0;
      size_q        <= '0;
      size_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      tx_mem_addr_q <= '0;
      tx_mem_chan_q <= '0;
      rc_mem_addr_q <= '0;
      rc_mem_chan_q <= '0;
      rc_mem_data_q <= '0;
      rc_mem_we_q   <= 1'b0;
      xfer_done_q   <= 1'b0;
      xfer_abort_q  <= 1'b0;
      xfer_len_q    <= '0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      sck_prev_q    <= sck_prev_d;
      ss_prev_q     <= ss_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      chan_q        <= chan_d;
      get_q         <= get_d;
      size_q        <= size_d;
      size_cnt_q    <= size_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      tx_mem_addr_q <= tx_mem_addr_d;
      tx_mem_chan_q <= tx_mem_chan_d;
      rc_mem_addr_q <= rc_mem_addr_d;
      rc_mem_chan_q <= rc_mem_chan_d;
      rc_mem_data_q <= rc_mem_data_d;
      rc_mem_we_q   <= rc_mem_we_d;
      xfer_done_q   <= xfer_done_d;
      xfer_abort_q  <= xfer_abort_d;
      xfer_len_q    <= xfer_len_d;
    end
  end

  // Output drive; MISO idles low when deselected or ignoring a frame
  always_comb begin
    SPI_MISO  = ~ss_s & (state_q != ST_IGNORE) & tx_shift_q[7];
    txMemAddr = tx_mem_addr_q;
    txMemChan = tx_mem_chan_q;
    rcMemAddr = rc_mem_addr_q;
    rcMemChan = rc_mem_chan_q;
    rcMemData = rc_mem_data_q;
    rcMemWE   = rc_mem_we_q;
    xferDone  = xfer_done_q;
    xferAbort = xfer_abort_q;
    xferLen   = xfer_len_q;
  end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Self-checking bench for spi_cmd_slave: SPI master driver, tx memory model,
// write/pulse monitors and a transaction-level reference model.
module tb_spi_cmd_slave;

  localparam int AW   = 4;
  localparam int CW   = 2;
  localparam int SB   = 4;
  localparam int HALF = 6;

  logic        SysClk = 1'b0;
  logic        Reset;
  logic        SPI_CLK, SPI_MOSI, SPI_SS, SPI_MISO;
  logic [7:0]  statusIn;
  logic [AW-1:0] txMemAddr, rcMemAddr;
  logic [CW-1:0] txMemChan, rcMemChan;
  logic [7:0]  txMemData, rcMemData;
  logic        rcMemWE, xferDone, xferAbort;
  logic [8*SB-1:0] xferLen;

  int total = 0;
  int bad   = 0;

  always #5 SysClk = ~SysClk;

  spi_cmd_slave #(.AddrBits(AW), .ChanBits(CW), .SizeBytes(SB)) dut (
    .SysClk(SysClk), .Reset(Reset),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_SS(SPI_SS), .SPI_MISO(SPI_MISO),
    .statusIn(statusIn),
    .txMemAddr(txMemAddr), .txMemChan(txMemChan), .txMemData(txMemData),
    .rcMemAddr(rcMemAddr), .rcMemChan(rcMemChan), .rcMemData(rcMemData),
    .rcMemWE(rcMemWE), .xferDone(xferDone), .xferAbort(xferAbort), .xferLen(xferLen)
  );

  // tx memory with one-cycle read latency
  logic [7:0] txmem [0:3][0:15];
  always @(posedge SysClk) txMemData <= txmem[txMemChan][txMemAddr];

  // Monitors
  logic [13:0] wr_log[$];
  int          done_cnt = 0;
  int          abort_cnt = 0;
  logic [31:0] last_len = '0;
  always @(negedge SysClk) begin
    if (rcMemWE) wr_log.push_back({rcMemChan, rcMemAddr, rcMemData});
    if (xferDone) begin done_cnt++; last_len = xferLen; end
    if (xferAbort) begin abort_cnt++; last_len = xferLen; end
  end

  logic [7:0]  mosi_q[$];
  logic [7:0]  miso_q[$];
  logic [7:0]  exp_q[$];
  logic [13:0] exp_wr[$];

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      SPI_MOSI = b[i];
      repeat (HALF) @(negedge SysClk);
      r[i] = SPI_MISO;
      SPI_CLK = 1'b1;
      repeat (HALF) @(negedge SysClk);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int extra_bits);
    logic [7:0] r;
    miso_q.delete();
    SPI_SS = 1'b0;
    repeat (HALF) @(negedge SysClk);
    foreach (mosi_q[i]) begin
      spi_bits(mosi_q[i], 8, r);
      miso_q.push_back(r);
    end
    if (extra_bits > 0) spi_bits(8'hFF, extra_bits, r);
    repeat (HALF) @(negedge SysClk);
    SPI_SS = 1'b1;
    repeat (2 * HALF) @(negedge SysClk);
  endtask

  // Reference: builds frame and expected results for a whole transfer
  task automatic model_xfer(input int op, input int c, input int n);
    logic [7:0] d;
    logic [31:0] sz;
    mosi_q.delete(); exp_q.delete(); exp_wr.delete();
    sz = n;
    mosi_q.push_back({op[1:0], 4'($urandom), c[1:0]});
    exp_q.push_back(8'h00);
    for (int k = SB - 1; k >= 0; k--) begin
      mosi_q.push_back(sz[8*k +: 8]);
      exp_q.push_back(8'h00);
    end
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      mosi_q.push_back(d);
      if (op == 1) exp_q.push_back(txmem[c][i % 16]);
      else begin
        exp_q.push_back(8'h00);
        exp_wr.push_back({c[1:0], 4'(i % 16), d});
      end
    end
  endtask

  task automatic check_rx(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (miso_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s miso byte %0d: got %02h expected %02h", name, i, miso_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_wr(input string name);
    total++;
    if (wr_log.size() !== exp_wr.size()) begin
      bad++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_log.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        total++;
        if (wr_log[i] !== exp_wr[i]) begin
          bad++;
          $display("FAIL %s write %0d chan/addr/data: got %h expected %h", name, i, wr_log[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [63:0] got;
    got = {SPI_MISO, rcMemWE, xferDone, xferAbort, txMemAddr, txMemChan,
           rcMemAddr, rcMemChan, rcMemData, xferLen};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s outputs: got %h expected 0", name, got);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge SysClk);
    check_outputs_zero("reset");
    Reset = 1'b0;
    repeat (4) @(negedge SysClk);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_status(input logic [7:0] st);
    statusIn = st;
    mosi_q = '{8'h00, 8'h5A};
    exp_q  = '{8'h00, st};
    run_frame(0);
    check_rx("status");
  endtask

  task automatic test_put();
    int d0;
    d0 = done_cnt;
    wr_log.delete();
    mosi_q = '{8'h82, 8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    exp_wr = '{{2'd2, 4'd0, 8'h11}, {2'd2, 4'd1, 8'h22}, {2'd2, 4'd2, 8'h33}};
    run_frame(0);
    check_wr("put");
    total++;
    if (done_cnt - d0 !== 1 || last_len !== 32'd3) begin
      bad++;
      $display("FAIL put done: got cnt %0d len %0d expected 1 3", done_cnt - d0, last_len);
    end
  endtask

  task automatic test_get();
    int d0;
    d0 = done_cnt;
    txmem[1][0] = 8'hDE;
    txmem[1][1] = 8'hAD;
    mosi_q = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    exp_q  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD};
    run_frame(0);
    check_rx("get");
    total++;
    if (done_cnt - d0 !== 1 || last_len !== 32'd2) begin
      bad++;
      $display("FAIL get done: got cnt %0d len %0d expected 1 2", done_cnt - d0, last_len);
    end
  endtask

  task automatic test_size0_wrap();
    int d0;
    d0 = done_cnt;
    wr_log.delete();
    exp_wr.delete();
    mosi_q = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(0);
    check_wr("size0");
    total++;
    if (done_cnt - d0 !== 1 || last_len !== 32'd0) begin
      bad++;
      $display("FAIL size0 done: got cnt %0d len %0d expected 1 0", done_cnt - d0, last_len);
    end
    wr_log.delete();
    model_xfer(2, 0, 18);
    run_frame(0);
    check_wr("wrap");
    total++;
    if (last_len !== 32'd18) begin
      bad++;
      $display("FAIL wrap len: got %0d expected 18", last_len);
    end
  endtask

  task automatic test_abort();
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    wr_log.delete();
    model_xfer(2, 3, 5);
    for (int i = 0; i < 3; i++) begin
      void'(mosi_q.pop_back());
      void'(exp_wr.pop_back());
    end
    run_frame(3);
    check_wr("abort");
    total++;
    if (abort_cnt - a0 !== 1 || done_cnt - d0 !== 0 || last_len !== 32'd2) begin
      bad++;
      $display("FAIL abort pulses: got abort %0d done %0d len %0d expected 1 0 2",
               abort_cnt - a0, done_cnt - d0, last_len);
    end
    test_status(8'hA5);
  endtask

  task automatic test_illegal();
    int d0;
    d0 = done_cnt;
    wr_log.delete();
    exp_wr.delete();
    mosi_q = '{8'hC0, 8'h82, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7E};
    exp_q  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    statusIn = 8'hFF;
    run_frame(0);
    check_rx("illegal");
    check_wr("illegal");
    total++;
    if (done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL illegal done: got %0d expected 0", done_cnt - d0);
    end
    test_status(8'h3C);
  endtask

  task automatic test_random();
    int op, c, n, d0, a0;
    for (int t = 0; t < 8; t++) begin
      op = int'($urandom_range(0, 2));
      c  = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 20));
      if (op == 0) begin
        test_status(8'($urandom));
      end else begin
        for (int a = 0; a < 16; a++) txmem[c][a] = 8'($urandom);
        d0 = done_cnt;
        a0 = abort_cnt;
        wr_log.delete();
        model_xfer(op, c, n);
        run_frame(0);
        check_rx("rand_rx");
        check_wr("rand_wr");
        total++;
        if (done_cnt - d0 !== 1 || abort_cnt - a0 !== 0 || last_len !== 32'(n)) begin
          bad++;
          $display("FAIL rand done op %0d: got done %0d abort %0d len %0d expected 1 0 %0d",
                   op, done_cnt - d0, abort_cnt - a0, last_len, n);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int a0;
    a0 = abort_cnt;
    wr_log.delete();
    model_xfer(2, 1, 10);
    SPI_SS = 1'b0;
    repeat (HALF) @(negedge SysClk);
    for (int i = 0; i < 1 + SB + 3; i++) spi_bits(mosi_q[i], 8, r);
    repeat (HALF) @(negedge SysClk);
    Reset = 1'b1;
    @(negedge SysClk);
    check_outputs_zero("reset_mid");
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) spi_bits(8'h11, 8, r);
    repeat (HALF) @(negedge SysClk);
    SPI_SS = 1'b1;
    repeat (2 * HALF) @(negedge SysClk);
    while (exp_wr.size() > 3) void'(exp_wr.pop_back());
    check_wr("reset_mid");
    total++;
    if (abort_cnt - a0 !== 0) begin
      bad++;
      $display("FAIL reset_mid abort: got %0d expected 0", abort_cnt - a0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 16; a++) txmem[c][a] = '0;
    SPI_CLK  = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_SS   = 1'b1;
    statusIn = 8'hA5;
    test_reset();
    test_status(8'hA5);
    test_put();
    test_get();
    test_size0_wrap();
    statusIn = 8'hA5;
    test_abort();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_slave.md
# spi_cmd_slave

Parametrised, fully SysClk-domain SPI slave (mode 0) that decodes a command/size/payload framing protocol and moves payload bytes between the SPI master and per-channel byte memories. Successor to the existing dual-clock SPI interface: it supports multiple buffer channels, a configurable size-field width, a status readback command, and clean abort on chip-select deassertion, without any SPI_CLK-clocked logic. It sits between the board SPI pins and the tx/rx block RAMs.

## Interface
- AddrBits, 12: memory address width; payload addresses wrap modulo 2^AddrBits.
- ChanBits, 2: channel select width; the block addresses 2^ChanBits tx and rx channels.
- SizeBytes, 4: size-field length in bytes, sent MSB first; the counter width is 8*SizeBytes.
- SysClk  in  1  system clock; must be at least 8x the SPI_CLK frequency.
- Reset  in  1  synchronous, active-high.
- SPI_CLK, SPI_MOSI, SPI_SS  in  1 each  asynchronous pins, each passed through a 2-FF synchroniser. SPI_SS is active-low.
- SPI_MISO  out  1  serial data to the master.
- statusIn  in  8  byte returned by the STATUS command.
- txMemAddr  out  AddrBits; txMemChan  out  ChanBits  read port. txMemData  in  8 is valid 1 cycle after the address.
- rcMemAddr  out  AddrBits; rcMemChan  out  ChanBits; rcMemData  out  8; rcMemWE  out  1  write port.
- xferDone  out  1  1-cycle pulse when a GET or PUT payload completes.
- xferAbort  out  1  1-cycle pulse on SS rising edge while in SIZE or PAYLOAD.
- xferLen  out  8*SizeBytes  size of the last completed or aborted transfer.

## Operation
- Edge events are taken on the synchronised signals:
  - sck_rise and sck_fall are single-cycle events.
  - ss_fall and ss_rise are single-cycle events.
  - Bit and byte logic runs only while synchronised SS is 0.
- Receive:
  - On sck_rise, sync MOSI shifts into rxShift, MSB first, and bitCnt (3 bits) increments.
  - When bitCnt wraps 7->0, the byte_done event fires with the full byte.
- Transmit:
  - SPI_MISO = txShift[7] while SS is 0, and 0 while SS is 1.
  - On byte_done, txShift is loaded with the next byte (see states).
  - On sck_fall with bitCnt != 0, txShift shifts left with a 0 fill.
  - On sck_fall with bitCnt == 0 there is no shift, so bit 7 of the loaded byte is held.
- Command byte: cmd[7:6] is the opcode (00 STATUS, 01 GET, 10 PUT, 11 illegal) and cmd[ChanBits-1:0] is the channel, latched into chan.
- State machine, with states CMD, SIZE, PAYLOAD and IGNORE:
  - ss_fall: bitCnt <= 0, state <= CMD, txShift <= 0. This takes priority over all other transitions.
  - CMD, byte_done:
    - STATUS: txShift <= statusIn, stay in CMD.
    - GET: go to SIZE, txMemAddr <= 0, txMemChan <= chan, txShift <= 0.
    - PUT: go to SIZE, txShift <= 0.
    - Illegal opcode: go to IGNORE.
    - In every case sizeCnt <= 0 and byteCnt <= 0.
  - SIZE, byte_done: the size register shifts in the byte. After SizeBytes bytes:
    - If size == 0: pulse xferDone, set xferLen = 0, go to CMD.
    - Otherwise go to PAYLOAD. For GET, txShift <= txMemData (the byte at address 0) and txMemAddr increments.
  - PAYLOAD, byte_done:
    - PUT: one cycle after byte_done, rcMemWE = 1 for exactly 1 cycle, with rcMemData = byte, rcMemAddr = byteCnt[AddrBits-1:0] and rcMemChan = chan.
    - GET: txShift <= txMemData, then txMemAddr increments. The received byte is ignored.
    - byteCnt increments. When byteCnt == size-1: pulse xferDone, set xferLen = size, go to CMD, and load txShift with 0.
  - IGNORE: stay until ss_fall. SPI_MISO is 0.
- ss_rise:
  - Partial bits are discarded and no write is issued.
  - If the state is SIZE or PAYLOAD: pulse xferAbort and set xferLen = byteCnt (bytes completed so far).
  - State returns to CMD.
- Address arithmetic: addresses wrap modulo 2^AddrBits. byteCnt runs to the full 8*SizeBytes bits and does not wrap.

## Timing
- Reset values:
  - SPI_MISO, rcMemWE, xferDone, xferAbort, txMemAddr, txMemChan, rcMemAddr, rcMemChan, rcMemData, xferLen: all 0.
  - state = CMD, bitCnt = 0.
- Pin-to-event latency is 3 SysClk cycles (2-FF synchroniser plus edge register).
- byte_done fires on the same cycle as the 8th sck_rise event.
- rcMemWE and xferDone assert on byte_done+1.
- SPI_MISO reflects a new txShift on byte_done+1, which is before the next SPI_CLK falling edge at a clock ratio of at least 8x.
- The GET prefetch address is stable at least 8 SCK edges before use, which satisfies the 1-cycle read latency.
- If ss_rise and byte_done occur in the same cycle, the abort wins: no write and no xferDone.

## Test plan
- STATUS: statusIn=0xA5; send 0x00 then a dummy byte -> MISO returns 0x00, 0xA5.
- PUT, channel 2, SizeBytes=4: send 0x82, 00 00 00 03, 11 22 33 -> three rcMemWE pulses to chan 2 at addresses 0,1,2 with data 11,22,33; xferDone with xferLen=3.
- GET, channel 1: mem[1][0..1] = 0xDE, 0xAD; send 0x41, 00 00 00 02, then 2 dummy bytes -> MISO returns 00, 00 00 00 00, DE AD; xferDone with xferLen=2.
- Size 0 and wrap, with AddrBits=4: PUT with size 0 -> xferDone and no write; PUT with size 18 -> writes to addresses 0..15, then 0, 1.
- Abort: PUT with size 5, raise SS after 2 payload bytes plus 3 bits -> 2 writes, xferAbort with xferLen=2; the next ss_fall plus 0x00 returns statusIn.
- Illegal opcode and reset: cmd 0xC0 -> no writes and MISO 0 until SS cycles. Reset mid-PAYLOAD -> all outputs at reset values next cycle, and no further WE.
